// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - hz_state_t   : sequencer state encoding (RUN/LDSTALL/MDWAIT/HALT)
//   - pipe_ctrl_t  : bundle of pipeline-register write-enable/clear controls
//   - ctrl_*()     : canned control patterns used by the sequencer
//   - REG_AW_DEFAULT, LDCNT_W : default register-address width, stall
//                               counter width
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int LDCNT_W        = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2,
    HALT    = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_clear;
    logic id_ex_wen;
    logic id_ex_clear;
    logic ex_mem_wen;
    logic ex_mem_clear;
    logic mem_wb_wen;
  } pipe_ctrl_t;

  // Free-running pipeline: every register loads, nothing is cleared.
  function automatic pipe_ctrl_t ctrl_run();
    pipe_ctrl_t c;
    c.pc_wen       = 1'b1;
    c.if_id_wen    = 1'b1;
    c.if_id_clear  = 1'b0;
    c.id_ex_wen    = 1'b1;
    c.id_ex_clear  = 1'b0;
    c.ex_mem_wen   = 1'b1;
    c.ex_mem_clear = 1'b0;
    c.mem_wb_wen   = 1'b1;
    return c;
  endfunction

  // Held in reset: nothing loads, every clearable register is cleared.
  function automatic pipe_ctrl_t ctrl_reset();
    pipe_ctrl_t c;
    c.pc_wen       = 1'b0;
    c.if_id_wen    = 1'b0;
    c.if_id_clear  = 1'b1;
    c.id_ex_wen    = 1'b0;
    c.id_ex_clear  = 1'b1;
    c.ex_mem_wen   = 1'b0;
    c.ex_mem_clear = 1'b1;
    c.mem_wb_wen   = 1'b0;
    return c;
  endfunction

  // Load-use bubble: PC and IF_ID hold, a NOP is injected into ID_EX.
  function automatic pipe_ctrl_t ctrl_bubble();
    pipe_ctrl_t c;
    c              = ctrl_run();
    c.pc_wen       = 1'b0;
    c.if_id_wen    = 1'b0;
    c.id_ex_clear  = 1'b1;
    return c;
  endfunction

  // Front-end freeze: the instruction in EX is held, nothing follows it
  // into MEM, older instructions in MEM/WB keep draining.
  function automatic pipe_ctrl_t ctrl_freeze();
    pipe_ctrl_t c;
    c              = ctrl_run();
    c.pc_wen       = 1'b0;
    c.if_id_wen    = 1'b0;
    c.id_ex_wen    = 1'b0;
    c.ex_mem_clear = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard check: the instruction in EX is a
// load writing a non-zero register that the instruction in ID reads.
// Ports:
//   id_rs1, id_rs2         : source register addresses in ID
//   id_use_rs1, id_use_rs2 : ID instruction actually reads that source
//   ex_rd                  : destination register of the EX instruction
//   ex_rfwe, ex_dmrd       : EX writes the register file / EX is a load
//   haz                    : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rfwe,
  input  logic              ex_dmrd,
  output logic              haz
);

  logic rs1_match;
  logic rs2_match;

  // x0 is hard-wired to zero, so a load targeting it never creates a
  // dependency and must not stall the pipeline.
  always_comb begin
    rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    haz       = ex_dmrd && ex_rfwe && (ex_rd != '0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
// Central stall/flush sequencer for the 5-stage pipeline. Drives the
// write-enable/clear pins of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB
// registers. Handles load-use bubbles (optionally multi-cycle), taken
// branch flushes, multi-cycle MDU waits and ebreak halt/resume.
// Outputs are combinational from state and inputs (Mealy).
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs1/id_rs2            : ID source addresses
//   id_use_rs1/id_use_rs2    : ID reads that source
//   ex_rd/ex_rfwe/ex_dmrd    : EX destination, regfile write, load
//   ex_br_taken              : EX redirects the PC
//   ex_mdu_start, mdu_done   : multi-cycle MDU op pending / result ready
//   ex_ebreak, resume        : halt request / debug resume pulse
//   pc_wen ... mem_wb_wen    : pipeline register controls (clear wins)
//   halted                   : core parked by ebreak
//   perf_*                   : performance counters (optional)
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the CNT_W-bit
// counters perf_ld_stall, perf_flush, perf_mdu_stall, perf_halt_cyc.
// ---------------------------------------------------------------------------
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int REG_AW            = REG_AW_DEFAULT,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rfwe,
  input  logic              ex_dmrd,
  input  logic              ex_br_taken,
  input  logic              ex_mdu_start,
  input  logic              mdu_done,
  input  logic              ex_ebreak,
  input  logic              resume,
  output logic              pc_wen,
  output logic              if_id_wen,
  output logic              if_id_clear,
  output logic              id_ex_wen,
  output logic              id_ex_clear,
  output logic              ex_mem_wen,
  output logic              ex_mem_clear,
  output logic              mem_wb_wen,
  output logic              halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_ld_stall,
  output logic [CNT_W-1:0]  perf_flush,
  output logic [CNT_W-1:0]  perf_mdu_stall,
  output logic [CNT_W-1:0]  perf_halt_cyc
`endif
);

  // The stall counter is 4 bits wide, so the bubble count is capped at 15.
  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_ld_stall
    $error("hazard_sequencer: LOAD_STALL_CYCLES must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_sequencer: CNT_W must be at least 1");
  end

  localparam logic [LDCNT_W-1:0] LD_RELOAD = LDCNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_t          state;
  hz_state_t          state_nx;
  logic [LDCNT_W-1:0] ldcnt;
  logic [LDCNT_W-1:0] ldcnt_nx;
  logic               haz;
  logic               mdu_stall_req;
  pipe_ctrl_t         ctrl;

  // Load-use detection is shared with the forwarding unit, hence its own
  // module.
  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_detect (
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd     (ex_rd),
    .ex_rfwe   (ex_rfwe),
    .ex_dmrd   (ex_dmrd),
    .haz       (haz)
  );

  // An MDU op whose result arrives in the same cycle it reaches EX needs
  // no wait at all.
  assign mdu_stall_req = ex_mdu_start && !mdu_done;

  // State register and remaining-bubble counter. Reset aborts any stall or
  // halt immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      ldcnt <= '0;
    end else begin
      state <= state_nx;
      ldcnt <= ldcnt_nx;
    end
  end

  // Next-state and output decode. In RUN the events are ranked
  // ebreak > mdu > branch > load-use: a taken branch makes the ID
  // instruction wrong-path, so a hazard it raises is meaningless. While in
  // LDSTALL the ID/EX inputs are not looked at, since EX holds a bubble.
  // Reset overrides the decoded controls last so it takes effect without
  // waiting for a clock edge.
  always_comb begin
    state_nx = state;
    ldcnt_nx = ldcnt;
    ctrl     = ctrl_run();

    unique case (state)
      RUN: begin
        if (ex_ebreak) begin
          ctrl     = ctrl_freeze();
          state_nx = HALT;
        end else if (mdu_stall_req) begin
          ctrl     = ctrl_freeze();
          state_nx = MDWAIT;
        end else if (ex_br_taken) begin
          ctrl.if_id_clear = 1'b1;
          ctrl.id_ex_clear = 1'b1;
        end else if (haz) begin
          ctrl = ctrl_bubble();
          if (LOAD_STALL_CYCLES > 1) begin
            state_nx = LDSTALL;
            ldcnt_nx = LD_RELOAD;
          end
        end
      end

      LDSTALL: begin
        ctrl     = ctrl_bubble();
        ldcnt_nx = ldcnt - 1'b1;
        if (ldcnt == LDCNT_W'(1)) begin
          state_nx = RUN;
        end
      end

      MDWAIT: begin
        if (mdu_done) begin
          state_nx = RUN;
        end else begin
          ctrl = ctrl_freeze();
        end
      end

      HALT: begin
        ctrl            = ctrl_freeze();
        ctrl.ex_mem_wen = 1'b0;
        if (resume) begin
          ctrl.id_ex_clear = 1'b1;
          state_nx         = RUN;
        end
      end

      default: begin
        state_nx = RUN;
      end
    endcase

    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  assign pc_wen       = ctrl.pc_wen;
  assign if_id_wen    = ctrl.if_id_wen;
  assign if_id_clear  = ctrl.if_id_clear;
  assign id_ex_wen    = ctrl.id_ex_wen;
  assign id_ex_clear  = ctrl.id_ex_clear;
  assign ex_mem_wen   = ctrl.ex_mem_wen;
  assign ex_mem_clear = ctrl.ex_mem_clear;
  assign mem_wb_wen   = ctrl.mem_wb_wen;
  assign halted       = (state == HALT) && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic ld_bubble;
  logic flush_evt;

  // A flush only counts when the branch actually won the RUN priority; a
  // load bubble is every RUN hazard cycle plus every LDSTALL cycle.
  assign flush_evt = (state == RUN) && !ex_ebreak && !mdu_stall_req && ex_br_taken;
  assign ld_bubble = (state == LDSTALL) ||
                     ((state == RUN) && !ex_ebreak && !mdu_stall_req && !ex_br_taken && haz);

  // Free-running event counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_stall  <= '0;
      perf_flush     <= '0;
      perf_mdu_stall <= '0;
      perf_halt_cyc  <= '0;
    end else begin
      perf_ld_stall  <= perf_ld_stall  + CNT_W'(ld_bubble);
      perf_flush     <= perf_flush     + CNT_W'(flush_evt);
      perf_mdu_stall <= perf_mdu_stall + CNT_W'(state == MDWAIT);
      perf_halt_cyc  <= perf_halt_cyc  + CNT_W'(state == HALT);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hazard_sequencer
// Drives two sequencers (LOAD_STALL_CYCLES = 1 and 3) from the same inputs
// and compares every output against a behavioural model of the pipeline
// control rules, with directed steps followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_hazard_sequencer;

  localparam int AW    = 5;
  localparam int LSC_A = 1;
  localparam int LSC_B = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_rfwe, ex_dmrd;
  logic          ex_br_taken, ex_mdu_start, mdu_done, ex_ebreak, resume;

  logic [1:0] pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear;
  logic [1:0] ex_mem_wen, ex_mem_clear, mem_wb_wen, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_stall [2];
  logic [31:0] perf_flush    [2];
  logic [31:0] perf_mdu_stall[2];
  logic [31:0] perf_halt_cyc [2];
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: extra bubbles still owed, waiting on MDU, parked by ebreak.
  int          m_bub [2];
  bit          m_mdu [2];
  bit          m_halt[2];
  logic [31:0] m_pld [2];
  logic [31:0] m_pfl [2];
  logic [31:0] m_pmd [2];
  logic [31:0] m_phl [2];

  always #5 clk = ~clk;

  hazard_sequencer #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC_A), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_rfwe(ex_rfwe), .ex_dmrd(ex_dmrd), .ex_br_taken(ex_br_taken),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .ex_ebreak(ex_ebreak), .resume(resume),
    .pc_wen(pc_wen[0]), .if_id_wen(if_id_wen[0]), .if_id_clear(if_id_clear[0]),
    .id_ex_wen(id_ex_wen[0]), .id_ex_clear(id_ex_clear[0]), .ex_mem_wen(ex_mem_wen[0]),
    .ex_mem_clear(ex_mem_clear[0]), .mem_wb_wen(mem_wb_wen[0]), .halted(halted[0])
`ifdef HAZARD_PERF_CNT_EN
    , .perf_ld_stall(perf_ld_stall[0]), .perf_flush(perf_flush[0]),
    .perf_mdu_stall(perf_mdu_stall[0]), .perf_halt_cyc(perf_halt_cyc[0])
`endif
  );

  hazard_sequencer #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC_B), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_rfwe(ex_rfwe), .ex_dmrd(ex_dmrd), .ex_br_taken(ex_br_taken),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .ex_ebreak(ex_ebreak), .resume(resume),
    .pc_wen(pc_wen[1]), .if_id_wen(if_id_wen[1]), .if_id_clear(if_id_clear[1]),
    .id_ex_wen(id_ex_wen[1]), .id_ex_clear(id_ex_clear[1]), .ex_mem_wen(ex_mem_wen[1]),
    .ex_mem_clear(ex_mem_clear[1]), .mem_wb_wen(mem_wb_wen[1]), .halted(halted[1])
`ifdef HAZARD_PERF_CNT_EN
    , .perf_ld_stall(perf_ld_stall[1]), .perf_flush(perf_flush[1]),
    .perf_mdu_stall(perf_mdu_stall[1]), .perf_halt_cyc(perf_halt_cyc[1])
`endif
  );

  // Load-use rule straight from the pipeline definition.
  function automatic bit model_haz();
    bit r1;
    bit r2;
    r1 = id_use_rs1 && (id_rs1 == ex_rd);
    r2 = id_use_rs2 && (id_rs2 == ex_rd);
    return ex_dmrd && ex_rfwe && (ex_rd != 0) && (r1 || r2);
  endfunction

  // Expected {pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear,
  // ex_mem_wen, ex_mem_clear, mem_wb_wen, halted} for instance k.
  function automatic logic [8:0] model_out(int k);
    logic pc, ifw, ifc, idw, idc, exw, exc, mw, h;
    bit   freeze, bubble;
    pc = 1; ifw = 1; ifc = 0; idw = 1; idc = 0; exw = 1; exc = 0; mw = 1; h = 0;
    freeze = 0;
    bubble = 0;
    if (rst) begin
      pc = 0; ifw = 0; ifc = 1; idw = 0; idc = 1; exw = 0; exc = 1; mw = 0;
    end else if (m_halt[k]) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; exc = 1; h = 1;
      idc = resume;
    end else if (m_bub[k] > 0) begin
      bubble = 1;
    end else if (m_mdu[k]) begin
      freeze = !mdu_done;
    end else if (ex_ebreak || (ex_mdu_start && !mdu_done)) begin
      freeze = 1;
    end else if (ex_br_taken) begin
      ifc = 1; idc = 1;
    end else if (model_haz()) begin
      bubble = 1;
    end
    if (freeze) begin
      pc = 0; ifw = 0; idw = 0; exc = 1;
    end
    if (bubble) begin
      pc = 0; ifw = 0; idc = 1;
    end
    return {pc, ifw, ifc, idw, idc, exw, exc, mw, h};
  endfunction

  task automatic resetModels();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_mdu[k] = 0; m_halt[k] = 0;
      m_pld[k] = 0; m_pfl[k] = 0; m_pmd[k] = 0; m_phl[k] = 0;
    end
  endtask

  // Move the model across one rising edge using the inputs of the cycle
  // that just ended.
  task automatic advanceModels();
    int lsc;
    if (rst) begin
      resetModels();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      lsc = (k == 0) ? LSC_A : LSC_B;
      if (m_halt[k]) begin
        m_phl[k]++;
        if (resume) m_halt[k] = 0;
      end else if (m_bub[k] > 0) begin
        m_pld[k]++;
        m_bub[k]--;
      end else if (m_mdu[k]) begin
        m_pmd[k]++;
        if (mdu_done) m_mdu[k] = 0;
      end else if (ex_ebreak) begin
        m_halt[k] = 1;
      end else if (ex_mdu_start && !mdu_done) begin
        m_mdu[k] = 1;
      end else if (ex_br_taken) begin
        m_pfl[k]++;
      end else if (model_haz()) begin
        m_pld[k]++;
        m_bub[k] = lsc - 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] exp_v, got_v;
    for (int k = 0; k < 2; k++) begin
      exp_v = model_out(k);
      got_v = {pc_wen[k], if_id_wen[k], if_id_clear[k], id_ex_wen[k], id_ex_clear[k],
               ex_mem_wen[k], ex_mem_clear[k], mem_wb_wen[k], halted[k]};
      checks++;
      assert (got_v === exp_v) else begin
        failures++;
        $error("[TB] FAIL %s[lsc%0d]: observed=%b expected=%b", tag, (k == 0) ? LSC_A : LSC_B, got_v, exp_v);
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic checkPerf(input string tag);
    for (int k = 0; k < 2; k++) begin
      checks++;
      assert ({perf_ld_stall[k], perf_flush[k], perf_mdu_stall[k], perf_halt_cyc[k]} ===
              {m_pld[k], m_pfl[k], m_pmd[k], m_phl[k]}) else begin
        failures++;
        $error("[TB] FAIL %s[%0d]: observed ld=%0d fl=%0d md=%0d hl=%0d expected ld=%0d fl=%0d md=%0d hl=%0d",
               tag, k, perf_ld_stall[k], perf_flush[k], perf_mdu_stall[k], perf_halt_cyc[k],
               m_pld[k], m_pfl[k], m_pmd[k], m_phl[k]);
      end
    end
  endtask
`endif

  task automatic idleInputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_rfwe = 0; ex_dmrd = 0; ex_br_taken = 0;
    ex_mdu_start = 0; mdu_done = 0; ex_ebreak = 0; resume = 0;
  endtask

  // Called at a falling edge with the inputs already set: check the
  // combinational outputs mid-cycle, clock once, advance the model, and
  // return at the next falling edge.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput(tag);
    @(posedge clk);
    advanceModels();
    @(negedge clk);
  endtask

  task automatic setLoadUse(input logic [AW-1:0] rd, input logic [AW-1:0] rs);
    idleInputs();
    ex_dmrd = 1; ex_rfwe = 1; ex_rd = rd; id_rs1 = rs; id_use_rs1 = 1;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    resetModels();
    #1;
    checkOutput("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resetModels();

    idleInputs();
    applyStimulus("idle");

    // Load x5 followed by a reader of x5.
    setLoadUse(5'd5, 5'd5);
    applyStimulus("loaduse_x5");
    idleInputs();
    for (int i = 0; i < 4; i++) applyStimulus("loaduse_tail");

    // Same hazard via rs2 only.
    setLoadUse(5'd9, 5'd0);
    id_use_rs1 = 0; id_rs2 = 5'd9; id_use_rs2 = 1;
    applyStimulus("loaduse_rs2");
    idleInputs();
    for (int i = 0; i < 3; i++) applyStimulus("loaduse_rs2_tail");

    // A load to x0 never stalls.
    setLoadUse(5'd0, 5'd0);
    applyStimulus("loaduse_x0");
    idleInputs();
    applyStimulus("after_x0");

    // Taken branch beats a simultaneous hazard.
    setLoadUse(5'd7, 5'd7);
    ex_br_taken = 1;
    applyStimulus("branch_over_haz");
    idleInputs();
    applyStimulus("after_branch");

    // MDU op whose result appears after 5 frozen cycles.
    idleInputs();
    ex_mdu_start = 1;
    for (int i = 0; i < 5; i++) applyStimulus("mdu_wait");
    mdu_done = 1;
    applyStimulus("mdu_done");
    idleInputs();
    applyStimulus("after_mdu");

    // MDU result ready immediately: no stall.
    ex_mdu_start = 1; mdu_done = 1;
    applyStimulus("mdu_instant");
    idleInputs();

    // ebreak, ten halted cycles, then a resume pulse.
    resume = 1;
    applyStimulus("resume_in_run");
    idleInputs();
    ex_ebreak = 1;
    applyStimulus("ebreak");
    for (int i = 0; i < 10; i++) applyStimulus("halted");
    resume = 1;
    applyStimulus("resume");
    idleInputs();
    applyStimulus("after_resume");
`ifdef HAZARD_PERF_CNT_EN
    checkPerf("perf_directed");
`endif

    // Reset asserted mid-MDWAIT between clock edges.
    ex_mdu_start = 1;
    applyStimulus("mdu_before_rst");
    applyStimulus("mdu_before_rst");
    rst = 1'b1;
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    advanceModels();
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    applyStimulus("post_reset_run");
`ifdef HAZARD_PERF_CNT_EN
    checkPerf("perf_after_reset");
`endif

    // Randomized traffic with small register numbers so hazards are common.
    for (int i = 0; i < 600; i++) begin
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      id_use_rs1   = ($urandom_range(0, 99) < 70);
      id_use_rs2   = ($urandom_range(0, 99) < 50);
      ex_rfwe      = ($urandom_range(0, 99) < 70);
      ex_dmrd      = ($urandom_range(0, 99) < 50);
      ex_br_taken  = ($urandom_range(0, 99) < 15);
      ex_mdu_start = ($urandom_range(0, 99) < 10);
      mdu_done     = ($urandom_range(0, 99) < 30);
      ex_ebreak    = ($urandom_range(0, 99) < 3);
      resume       = ($urandom_range(0, 99) < 25);
      applyStimulus("random");
    end
`ifdef HAZARD_PERF_CNT_EN
    checkPerf("perf_random");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable and clear of the IF_ID, ID_EX, EX_MEM and MEM_WB inter-stage registers and the PC register.
- Resolves load-use hazards (multi-cycle when data-memory latency > 1), taken-branch/jump flushes, multi-cycle MDU operations and ebreak halt/resume.
- Sits beside the control unit; all outputs feed the pipeline registers' wen/clear pins directly.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  REG_AW  rs1 address of the instruction in ID.
- id_rs2  in  REG_AW  rs2 address of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_rfwe  in  1  EX instruction writes the register file.
- ex_dmrd  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX resolved a taken branch/jump (PC redirect).
- ex_mdu_start  in  1  EX holds a multi-cycle MDU op whose result is not ready.
- mdu_done  in  1  MDU result valid this cycle.
- ex_ebreak  in  1  EX holds ebreak.
- resume  in  1  debug resume pulse.
- pc_wen  out  1  PC register write enable.
- if_id_wen  out  1  IF_ID write enable.
- if_id_clear  out  1  IF_ID clear (insert NOP).
- id_ex_wen  out  1  ID_EX write enable.
- id_ex_clear  out  1  ID_EX clear (zero ctrl and instruction).
- ex_mem_wen  out  1  EX_MEM write enable.
- ex_mem_clear  out  1  EX_MEM clear.
- mem_wb_wen  out  1  MEM_WB write enable.
- halted  out  1  core halted by ebreak.

Behaviour:
- States: RUN, LDSTALL, MDWAIT, HALT. 2-bit state register plus a 4-bit stall counter ldcnt.
- Outputs are combinational from state and inputs (zero-latency Mealy). The state register updates on posedge clk.
- While rst is high: state=RUN, ldcnt=0, all *_wen=0, all *_clear=1, halted=0. Asserting rst mid-stall or mid-halt aborts immediately to this condition.
- Default (no event): all wen=1, all clear=0.
- Hazard definition: haz = ex_dmrd & ex_rfwe & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). A write to x0 never stalls.
- RUN evaluates events in priority order ebreak > mdu > branch > load-use:
  - ex_ebreak:
    - Drive pc_wen=0, if_id_wen=0, id_ex_wen=0, ex_mem_clear=1; mem_wb_wen=1 so older instructions drain.
    - Next state HALT.
  - ex_mdu_start & ~mdu_done:
    - Drive pc_wen=0, if_id_wen=0, id_ex_wen=0, ex_mem_clear=1.
    - Next state MDWAIT.
    - If mdu_done is already high with ex_mdu_start, there is no stall.
  - ex_br_taken:
    - Drive if_id_clear=1, id_ex_clear=1; PC writes the redirect target.
    - Stay in RUN. A simultaneous haz is ignored because the ID instruction is wrong-path.
  - haz:
    - Drive pc_wen=0, if_id_wen=0, id_ex_clear=1.
    - If LOAD_STALL_CYCLES>1, go to LDSTALL with ldcnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
- LDSTALL:
  - Keep pc_wen=0, if_id_wen=0, id_ex_clear=1; decrement ldcnt.
  - When ldcnt==1, go to RUN.
  - Inputs from ID/EX are not re-evaluated here; EX holds a bubble.
- MDWAIT:
  - Hold the RUN mdu freeze outputs until mdu_done=1.
  - In the mdu_done cycle: all wen=1, no clears, go to RUN.
- HALT:
  - halted=1; pc/if_id/id_ex/ex_mem wen=0, ex_mem_clear=1, mem_wb_wen=1.
  - A resume pulse returns to RUN, with id_ex_clear=1 in that cycle so ebreak retires exactly once.
  - resume in any other state is ignored.
- clear has priority over wen at each register; both may be 1 simultaneously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_ld_stall, perf_flush, perf_mdu_stall, perf_halt_cyc, each CNT_W wide:
  - Counts, respectively, load-use bubbles inserted (each cycle), taken-branch flushes (events), MDWAIT cycles, and HALT cycles.
  - Counters wrap modulo 2^CNT_W and reset to 0 on rst.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds the state enum (RUN=2'd0, LDSTALL=2'd1, MDWAIT=2'd2, HALT=2'd3) and the REG_AW default.
- One sub-module, hazard_detect: purely combinational haz computation. Reused by the forwarding unit.

Test Plan:
- Load x5 in EX (ex_dmrd=1, ex_rfwe=1, ex_rd=5), ID add reads rs1=5, LOAD_STALL_CYCLES=1 -> one cycle of pc_wen=0, if_id_wen=0, id_ex_clear=1, then defaults. Repeat with ex_rd=0 -> no stall.
- LOAD_STALL_CYCLES=3, same hazard -> exactly 3 consecutive bubble cycles, state back to RUN on the 4th.
- ex_br_taken=1 together with haz=1 -> if_id_clear=1, id_ex_clear=1, pc_wen=1, no stall cycle.
- ex_mdu_start=1, mdu_done after 5 cycles -> front stages frozen and ex_mem_clear=1 for 5 cycles, all wen=1 in the done cycle.
- ex_ebreak=1 -> halted=1 next cycle and held for 10 cycles; resume pulse -> halted=0, id_ex_clear=1 for one cycle. With HAZARD_PERF_CNT_EN, perf_halt_cyc increments by the number of HALT cycles.
- rst asserted mid-MDWAIT -> outputs go to the reset values immediately (asynchronously); after release, state is RUN.
